// File: rtl/cpu_pkg.sv
// Shared types and sizing for the register bank.
// Holds the register width, count and the hard-wired zero index.
package cpu_pkg;

    localparam int WIDTH    = 64;
    localparam int NREGS    = 32;
    localparam int ZERO_REG = 31;
    localparam int CNT_W    = 2;
    localparam int IDX_W    = $clog2(NREGS);

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [IDX_W-1:0] reg_idx_t;

    function automatic logic [NREGS-1:0] onehot(input reg_idx_t idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/pending_counter.sv
// Saturating up/down count of in-flight writes to one register.
// Increments are dropped at full, decrements are dropped at zero.
module pending_counter
    import cpu_pkg::*;
#(
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          full
);

    logic do_inc;
    logic do_dec;

    assign full    = &count;
    assign nonzero = |count;
    assign do_inc  = inc && !full;
    assign do_dec  = dec && nonzero;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (do_inc && !do_dec) begin
            count <= count + 1'b1;
        end else if (do_dec && !do_inc) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/register_bank_storage.sv
// Architectural register array with a per-register pending-write scoreboard.
// The whole array is exported so decode can build its own read muxes.
module register_bank_storage
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  reg_idx_t         wr_addr,
    input  word_t            wr_data,
    input  logic             iss_en,
    input  reg_idx_t         iss_addr,
    output word_t            regs [NREGS-1:0],
    output logic [NREGS-1:0] pending,
    output logic             iss_ready
);

    logic [NREGS-1:0] wr_sel;
    logic [NREGS-1:0] full;

    assign wr_sel    = wr_en ? onehot(wr_addr) : '0;
    // Only the counters feed readiness, keeping wr_* off this path.
    assign iss_ready = !full[iss_addr];

    for (genvar g = 0; g < NREGS; g++) begin : g_reg
        if (g == ZERO_REG) begin : g_zero
            assign regs[g]    = '0;
            assign pending[g] = 1'b0;
            assign full[g]    = 1'b0;
        end else begin : g_live
            logic [CNT_W-1:0] count;
            logic             inc;
            logic             dec;

            assign inc = iss_en && iss_ready
                      && (iss_addr == reg_idx_t'(g));
            assign dec = wr_sel[g] && (count != '0);

            always_ff @(posedge clk) begin
                if (reset) begin
                    regs[g] <= '0;
                end else if (wr_sel[g]) begin
                    regs[g] <= wr_data;
                end
            end

            pending_counter #(
                .CW(CNT_W)
            ) u_cnt (
                .clk    (clk),
                .reset  (reset),
                .inc    (inc),
                .dec    (dec),
                .count  (count),
                .nonzero(pending[g]),
                .full   (full[g])
            );
        end
    end

endmodule
